// File: rtl/tcm_dec_tmu_hd_rel_pkg.sv
// -----------------------------------------------------------------------------
// tcm_dec_tmu_hd_rel_pkg
// Shared decoder types for the hard-decision / reliability unit.
//   symb_m_value_t : point metric (unsigned, larger is better)
//   symb_hd_t      : hard-decision point index
//   hd_node_t      : comparison-tree node {best metric, best index, second-best}
// The typedefs describe the default configuration (8-bit metrics, 8 points).
// Parameterised users build the same node layout at their own widths and
// hand it to the merge node through its type parameter.
// -----------------------------------------------------------------------------
package tcm_dec_tmu_hd_rel_pkg;

  localparam int cSYMB_M_W  = 8;
  localparam int cPOINT_NUM = 8;

  localparam int cTIE_LOW  = 0;
  localparam int cTIE_HIGH = 1;

  // index width for a given point count; never below one bit
  function automatic int hd_width(input int point_num);
    return (point_num < 2) ? 1 : $clog2(point_num);
  endfunction

  localparam int cHD_W = hd_width(cPOINT_NUM);

  typedef logic [cSYMB_M_W-1:0] symb_m_value_t;
  typedef logic [cHD_W-1:0]     symb_hd_t;

  typedef struct packed {
    symb_m_value_t best;
    symb_hd_t      idx;
    symb_m_value_t second;
  } hd_node_t;

endpackage

// File: rtl/tcm_dec_tmu_hd_rel_if.sv
// -----------------------------------------------------------------------------
// tcm_dec_tmu_hd_rel_if
// Data bus of the hard-decision / reliability unit.
//   ival, isop, ieop : input group valid and frame tags
//   isymb_m          : [symbol][point] metrics of one group
//   ithr             : erasure threshold travelling with the group
//   oval, osop, oeop : output valid and aligned frame tags
//   ohd, omax        : per-symbol winning index and metric
//   omargin, oera    : per-symbol best minus second-best, erasure flag
// master drives the group and observes results; slave is the decoder side.
// -----------------------------------------------------------------------------
interface tcm_dec_tmu_hd_rel_if
  import tcm_dec_tmu_hd_rel_pkg::*;
#(
  parameter int pSYMB_M_W  = 8,
  parameter int pSYMB_NUM  = 4,
  parameter int pPOINT_NUM = 8
);

  localparam int HD_W = hd_width(pPOINT_NUM);

  logic                                           ival;
  logic                                           isop;
  logic                                           ieop;
  logic [pSYMB_NUM-1:0][pPOINT_NUM-1:0][pSYMB_M_W-1:0] isymb_m;
  logic [pSYMB_M_W-1:0]                           ithr;

  logic                                           oval;
  logic                                           osop;
  logic                                           oeop;
  logic [pSYMB_NUM-1:0][HD_W-1:0]                 ohd;
  logic [pSYMB_NUM-1:0][pSYMB_M_W-1:0]            omax;
  logic [pSYMB_NUM-1:0][pSYMB_M_W-1:0]            omargin;
  logic [pSYMB_NUM-1:0]                           oera;

  modport master (
    output ival, isop, ieop, isymb_m, ithr,
    input  oval, osop, oeop, ohd, omax, omargin, oera
  );

  modport slave (
    input  ival, isop, ieop, isymb_m, ithr,
    output oval, osop, oeop, ohd, omax, omargin, oera
  );

endinterface

// File: rtl/tcm_dec_tmu_hd_rel_node.sv
// -----------------------------------------------------------------------------
// tcm_dec_tmu_hd_node
// Registered merge of two comparison-tree nodes.
//   iclk, ireset_n, iclkena : clock, async active-low reset, clock enable
//   ia, ib                  : child nodes; ia always covers the lower indices
//   onode                   : merged node, one enabled cycle later
// Winner is the larger best metric; on equality pTIE_MODE=0 keeps ia (lower
// index), pTIE_MODE=1 keeps ib (higher index). The merged second-best is the
// larger of the loser's best and the winner's own second-best.
// -----------------------------------------------------------------------------
module tcm_dec_tmu_hd_node
  import tcm_dec_tmu_hd_rel_pkg::*;
#(
  parameter type node_t    = hd_node_t,
  parameter int  pTIE_MODE = cTIE_LOW
) (
  input  logic  iclk,
  input  logic  ireset_n,
  input  logic  iclkena,
  input  node_t ia,
  input  node_t ib,
  output node_t onode
);

  logic  a_wins;
  node_t merged;

  assign a_wins = (pTIE_MODE == cTIE_LOW) ? (ia.best >= ib.best)
                                          : (ia.best >  ib.best);

  always_comb begin
    merged = ib;
    if (a_wins) begin
      merged        = ia;
      merged.second = (ib.best > ia.second) ? ib.best : ia.second;
    end else begin
      merged.second = (ia.best > ib.second) ? ia.best : ib.second;
    end
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      onode <= '0;
    end else if (iclkena) begin
      onode <= merged;
    end
  end

endmodule

// File: rtl/tcm_dec_tmu_hd_rel.sv
// -----------------------------------------------------------------------------
// tcm_dec_tmu_hd_rel
// Hard decision and reliability per symbol of a multidimensional group.
//   iclk     : clock, rising edge
//   ireset_n : asynchronous active-low reset
//   iclkena  : clock enable, low freezes every register
//   bus      : slave side of tcm_dec_tmu_hd_rel_if (group in, decisions out)
// Each symbol is reduced by a registered binary tree of LOG levels, followed
// by one stage forming margin = best - second-best and the erasure flag.
// Latency is LOG+1 enabled cycles; one group accepted per enabled cycle.
// -----------------------------------------------------------------------------
module tcm_dec_tmu_hd_rel
  import tcm_dec_tmu_hd_rel_pkg::*;
#(
  parameter int pSYMB_M_W  = 8,
  parameter int pSYMB_NUM  = 4,
  parameter int pPOINT_NUM = 8,
  parameter int pTIE_MODE  = 0
) (
  input  logic                iclk,
  input  logic                ireset_n,
  input  logic                iclkena,
  tcm_dec_tmu_hd_rel_if.slave bus
);

  localparam int LOG      = hd_width(pPOINT_NUM);
  localparam int THR_SR_W = LOG * pSYMB_M_W;

  typedef logic [pSYMB_M_W-1:0] m_t;
  typedef logic [LOG-1:0]       hd_t;

  // same layout as hd_node_t, sized to this instance
  typedef struct packed {
    m_t  best;
    hd_t idx;
    m_t  second;
  } node_t;

  if (pPOINT_NUM < 2 || (1 << LOG) != pPOINT_NUM) begin : g_cfg_err
    $error("tcm_dec_tmu_hd_rel: pPOINT_NUM must be a power of 2, at least 2");
  end

  // Heap-ordered tree per symbol: leaves at pPOINT_NUM..2*pPOINT_NUM-1,
  // node n merges 2n and 2n+1, root at 1. Every leaf sits at the same depth,
  // so each tree level is exactly one register stage.
  node_t tree [pSYMB_NUM][1:2*pPOINT_NUM-1];

  for (genvar s = 0; s < pSYMB_NUM; s++) begin : g_symb
    for (genvar k = 0; k < pPOINT_NUM; k++) begin : g_leaf
      assign tree[s][pPOINT_NUM+k] = node_t'{best:   bus.isymb_m[s][k],
                                             idx:    hd_t'(k),
                                             second: '0};
    end
    for (genvar n = 1; n < pPOINT_NUM; n++) begin : g_node
      tcm_dec_tmu_hd_node #(
        .node_t    (node_t),
        .pTIE_MODE (pTIE_MODE)
      ) u_node (
        .iclk     (iclk),
        .ireset_n (ireset_n),
        .iclkena  (iclkena),
        .ia       (tree[s][2*n]),
        .ib       (tree[s][2*n+1]),
        .onode    (tree[s][n])
      );
    end
  end

  // side-band shift pipeline, one slot per tree level
  logic [LOG-1:0]                v_sr;
  logic [LOG-1:0]                sop_sr;
  logic [LOG-1:0]                eop_sr;
  logic [LOG-1:0][pSYMB_M_W-1:0] thr_sr;

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      v_sr   <= '0;
      sop_sr <= '0;
      eop_sr <= '0;
      thr_sr <= '0;
    end else if (iclkena) begin
      v_sr   <= LOG'({v_sr, bus.ival});
      sop_sr <= LOG'({sop_sr, bus.isop});
      eop_sr <= LOG'({eop_sr, bus.ieop});
      thr_sr <= THR_SR_W'({thr_sr, bus.ithr});
    end
  end

  logic                                tail_v;
  logic [pSYMB_NUM-1:0][pSYMB_M_W-1:0] margin_c;
  logic [pSYMB_NUM-1:0]                era_c;

  assign tail_v = v_sr[LOG-1];

  // root best >= root second by construction, so the difference never wraps
  always_comb begin
    margin_c = '0;
    era_c    = '0;
    for (int s = 0; s < pSYMB_NUM; s++) begin
      margin_c[s] = tree[s][1].best - tree[s][1].second;
      era_c[s]    = (margin_c[s] < thr_sr[LOG-1]);
    end
  end

  // tags are qualified by valid; decision data holds while no group arrives
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      bus.oval    <= 1'b0;
      bus.osop    <= 1'b0;
      bus.oeop    <= 1'b0;
      bus.ohd     <= '0;
      bus.omax    <= '0;
      bus.omargin <= '0;
      bus.oera    <= '0;
    end else if (iclkena) begin
      bus.oval <= tail_v;
      bus.osop <= tail_v & sop_sr[LOG-1];
      bus.oeop <= tail_v & eop_sr[LOG-1];
      if (tail_v) begin
        for (int s = 0; s < pSYMB_NUM; s++) begin
          bus.ohd[s]  <= tree[s][1].idx;
          bus.omax[s] <= tree[s][1].best;
        end
        bus.omargin <= margin_c;
        bus.oera    <= era_c;
      end
    end
  end

endmodule
